// File: rtl/mips_pc_pkg.sv
// rtl/mips_pc_pkg.sv - shared state encoding and address defaults for the PC sequencer
package mips_pc_pkg;

  typedef enum logic [1:0] {
    ST_RST,
    ST_REQ,
    ST_ISSUE,
    ST_HALTED
  } pc_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;
  localparam logic [31:0] INSTR_BYTES        = 32'd4;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - combinational next-PC selection and exception detection
module pc_next_mux
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic [31:0] i_pc,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_offset,
  input  logic        i_jump,
  input  logic [25:0] i_jump_target,
  input  logic        i_jr,
  input  logic [31:0] i_jr_addr,
  input  logic        i_exc,
  output logic [31:0] o_next_pc,
  output logic        o_take_exc
);

  logic [31:0] w_pc_plus4;
  logic        w_jr_misaligned;

  assign w_pc_plus4      = i_pc + INSTR_BYTES;
  assign w_jr_misaligned = i_jr && (i_jr_addr[1:0] != 2'b00);
  assign o_take_exc      = i_exc || w_jr_misaligned;

  // Priority: exception (incl. misaligned jr) > jr > jump > branch > sequential.
  always_comb begin
    o_next_pc = w_pc_plus4;
    if (o_take_exc)
      o_next_pc = EXC_VECTOR;
    else if (i_jr)
      o_next_pc = i_jr_addr;
    else if (i_jump)
      o_next_pc = {w_pc_plus4[31:28], i_jump_target, 2'b00};
    else if (i_br_taken)
      o_next_pc = w_pc_plus4 + (i_br_offset << 2);
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/issue sequencer holding pc, epc and the latched instruction
module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        exc,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] epc
);

  pc_state_t   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_imem_req;

  logic [31:0] w_next_pc;
  logic        w_take_exc;

  pc_next_mux #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_next_mux (
    .i_pc         (r_pc),
    .i_br_taken   (br_taken),
    .i_br_offset  (br_offset),
    .i_jump       (jump),
    .i_jump_target(jump_target),
    .i_jr         (jr),
    .i_jr_addr    (jr_addr),
    .i_exc        (exc),
    .o_next_pc    (w_next_pc),
    .o_take_exc   (w_take_exc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_RST;
      r_pc          <= RESET_PC;
      r_epc         <= 32'h0;
      r_instr       <= 32'h0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_RST: begin
          r_state    <= ST_REQ;
          r_imem_req <= 1'b1;
        end
        ST_REQ: begin
          if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Redirect inputs only matter in the handshake cycle.
          if (instr_ready) begin
            r_pc          <= w_next_pc;
            r_instr_valid <= 1'b0;
            if (w_take_exc)
              r_epc <= r_pc;
            if (halt) begin
              r_state <= ST_HALTED;
            end else begin
              r_state    <= ST_REQ;
              r_imem_req <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          r_imem_req <= 1'b0;
        end
        default: begin
          r_state <= ST_RST;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign epc         = r_epc;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with a reference next-PC model
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_offset = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'h0;
  logic        jr = 1'b0;
  logic [31:0] jr_addr = 32'h0;
  logic        exc = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic [31:0] epc;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_PC  (RST_PC),
    .EXC_VECTOR(EXC_VEC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .jump       (jump),
    .jump_target(jump_target),
    .jr         (jr),
    .jr_addr    (jr_addr),
    .exc        (exc),
    .halt       (halt),
    .pc         (pc),
    .epc        (epc)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] epc;
  } fetch_exp_t;

  fetch_exp_t  fetch_q[$];
  logic [31:0] instr_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] m_pc  = RST_PC;
  logic [31:0] m_epc = 32'h0;
  logic [31:0] last_data = 32'h0;
  int          cyc = 0;
  int          last_rise = 0;
  int          req_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fails++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Monitor: pops expectations whenever the DUT starts a fetch or presents an instruction.
  logic prev_req = 1'b0;
  logic prev_valid = 1'b0;
  always @(posedge clk) begin
    fetch_exp_t e;
    #2;
    if (imem_req && !prev_req) begin
      req_gap   = cyc - last_rise;
      last_rise = cyc;
      if (fetch_q.size() == 0) begin
        fail_now("unexpected_req");
      end else begin
        e = fetch_q.pop_front();
        check("imem_addr", imem_addr, e.addr);
        check("pc", pc, e.addr);
        check("epc", epc, e.epc);
      end
    end
    if (instr_valid && !prev_valid) begin
      if (instr_q.size() == 0) fail_now("unexpected_instr_valid");
      else check("instr", instr, instr_q.pop_front());
    end
    prev_req   = imem_req;
    prev_valid = instr_valid;
  end

  // Reference model: next PC from the architectural rules.
  task automatic model_step(input bit b_exc, input bit b_jr, input logic [31:0] b_jra,
                            input bit b_jmp, input logic [25:0] b_tgt,
                            input bit b_br, input logic [31:0] b_off);
    logic [31:0] pc4;
    pc4 = m_pc + 32'd4;
    if (b_exc || (b_jr && (b_jra % 4 != 0))) begin
      m_epc = m_pc;
      m_pc  = EXC_VEC;
    end else if (b_jr) m_pc = b_jra;
    else if (b_jmp) m_pc = (pc4 & 32'hF000_0000) + 32'(b_tgt) * 32'd4;
    else if (b_br) m_pc = pc4 + b_off * 32'd4;
    else m_pc = pc4;
  endtask

  task automatic clear_inputs();
    instr_ready = 1'b0; br_taken = 1'b0; br_offset = 32'h0; jump = 1'b0;
    jump_target = 26'h0; jr = 1'b0; jr_addr = 32'h0; exc = 1'b0; halt = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (imem_req) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) fail_now("wait_req_timeout");
  endtask

  task automatic fetch(input int delay);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    repeat (delay) @(negedge clk);
    last_data  = $urandom;
    imem_ack   = 1'b1;
    imem_rdata = last_data;
    instr_q.push_back(last_data);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic issue(input int stall, input bit b_exc, input bit b_jr, input logic [31:0] b_jra,
                       input bit b_jmp, input logic [25:0] b_tgt, input bit b_br,
                       input logic [31:0] b_off, input bit b_halt);
    check("valid_in_issue", {31'h0, instr_valid}, 32'h1);
    repeat (stall) begin
      instr_ready = 1'b0;
      br_taken = 1'($urandom_range(0, 1)); br_offset = $urandom;
      jump = 1'($urandom_range(0, 1)); jump_target = 26'($urandom);
      jr = 1'($urandom_range(0, 1)); jr_addr = $urandom;
      exc = 1'($urandom_range(0, 1)); halt = 1'($urandom_range(0, 1));
      imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
      @(negedge clk);
      check("instr_stable", instr, last_data);
    end
    imem_ack = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    instr_ready = 1'b1; exc = b_exc; jr = b_jr; jr_addr = b_jra; jump = b_jmp;
    jump_target = b_tgt; br_taken = b_br; br_offset = b_off; halt = b_halt;
    model_step(b_exc, b_jr, b_jra, b_jmp, b_tgt, b_br, b_off);
    if (!b_halt) fetch_q.push_back('{m_pc, m_epc});
    @(negedge clk);
    clear_inputs();
    imem_ack = 1'b0;
  endtask

  task automatic seq();
    issue(0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0, 0);
  endtask

  task automatic go_jr(input logic [31:0] a);
    issue(0, 0, 1, a, 0, 26'h0, 0, 32'h0, 0);
    fetch(0);
  endtask

  task automatic reset_assert();
    rst_n = 1'b0;
    clear_inputs();
    imem_ack = 1'b0;
    fetch_q.delete();
    instr_q.delete();
    m_pc  = RST_PC;
    m_epc = 32'h0;
  endtask

  task automatic reset_release();
    fetch_q.push_back('{RST_PC, 32'h0});
    rst_n = 1'b1;
  endtask

  initial begin
    int delay, stall, kind;
    bit ok;
    @(negedge clk);
    reset_assert();
    repeat (3) @(negedge clk);
    check("rst_pc", pc, RST_PC);
    check("rst_epc", epc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    reset_release();

    // Sequential run with same-cycle ack: 0x0, 0x4, 0x8 every second cycle.
    fetch(0); seq();
    fetch(0); check("gap_4", req_gap, 2); seq();
    fetch(0); check("gap_8", req_gap, 2); check("pc_8", pc, 32'h8); seq();
    fetch(0); seq();
    fetch(0); check("pc_10", pc, 32'h10);
    issue(3, 0, 0, 32'h0, 0, 26'h0, 1, 32'hFFFF_FFFE, 0);
    check("br_back", pc, 32'hC);
    fetch(1);

    go_jr(32'h3000_0000);
    issue(0, 0, 0, 32'h0, 1, 26'h0000_040, 0, 32'h0, 0);
    check("jump_pc", pc, 32'h3000_0100);
    fetch(2);
    go_jr(32'h3000_0000);
    issue(1, 0, 1, 32'h0000_0202, 0, 26'h0, 0, 32'h0, 0);
    check("misjr_pc", pc, 32'h80);
    check("misjr_epc", epc, 32'h3000_0000);
    fetch(0);

    go_jr(32'h40);
    issue(0, 1, 0, 32'h0, 1, 26'h0000_123, 0, 32'h0, 0);
    check("exc_pc", pc, 32'h80);
    check("exc_epc", epc, 32'h40);
    fetch(0);
    go_jr(32'hFFFF_FFFC);
    seq();
    check("wrap_pc", pc, 32'h0);
    fetch(3);

    // Reset while waiting for a delayed ack; the late ack must be dropped.
    seq();
    wait_req(ok);
    @(negedge clk); @(negedge clk);
    reset_assert();
    @(negedge clk);
    check("req_after_rst", {31'h0, imem_req}, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset_release();
    @(negedge clk);
    imem_ack = 1'b0;
    check("late_ack_instr", instr, 32'h0);
    check("late_ack_valid", {31'h0, instr_valid}, 32'h0);
    check("post_rst_pc", pc, RST_PC);
    fetch(0);

    for (int n = 0; n < 300; n++) begin
      delay = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      stall = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      kind  = $urandom_range(0, 19);
      if (kind == 0)
        issue(stall, 1, 0, 32'h0, 0, 26'h0, 0, 32'h0, 0);
      else if (kind < 4)
        issue(stall, 0, 1, $urandom & ((kind == 1) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC), 0, 26'h0, 0, 32'h0, 0);
      else if (kind < 7)
        issue(stall, 0, 0, 32'h0, 1, 26'($urandom), 1, $urandom, 0);
      else if (kind < 11)
        issue(stall, 0, 0, 32'h0, 0, 26'h0, 1, 32'($signed(10'($urandom))), 0);
      else
        seq();
      fetch(delay);
    end

    // Halt together with an exception: pc/epc update, then no more fetches.
    issue(1, 1, 0, 32'h0, 0, 26'h0, 0, 32'h0, 1);
    repeat (10) begin
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt_req", {31'h0, imem_req}, 32'h0);
      check("halt_valid", {31'h0, instr_valid}, 32'h0);
    end
    check("halt_pc", pc, m_pc);
    check("halt_epc", epc, m_epc);
    imem_ack = 1'b0;
    if (fetch_q.size() != 0) fail_now("fetch_q_not_drained");
    if (instr_q.size() != 0) fail_now("instr_q_not_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
